alu_writeback_stage: RTL and testbench
======================================

Name: alu_writeback_stage

Overview:
- Execute-to-writeback stage directly downstream of the 16-bit ALU.
- Captures each ALU result with its destination register and owns the architectural zero/carry flags, which it feeds back to the ALU flag inputs.
- Buffers register-file writes in a small in-order FIFO so the register-file write port can apply backpressure (the port is shared with load returns).
- Keeps a retired-operation counter.

Parameters:
- DEPTH, 2, write-buffer entries (power of two, ≥2)
- ADDR_W, 3, register index width
- ZERO_REG, 1, when 1, writes to register 0 are discarded

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept a result
- alu_out  in  17  ALU result; bit 16 is carry-out, bits 15:0 are data
- alu_zero  in  1  ALU zero flag out
- alu_carry  in  1  ALU carry flag out
- alu_cond_met  in  1  ALU condition result
- in_rd  in  ADDR_W  destination register
- in_wr_en  in  1  operation writes in_rd
- in_flags_en  in  1  operation updates flags
- zero_flag  out  1  architectural Z, to ALU zeroFlagIn
- carry_flag  out  1  architectural C, to ALU carryFlagIn
- rf_wr_en  out  1  write request (FIFO head valid)
- rf_wr_ready  in  1  register file accepts the write
- rf_wr_addr  out  ADDR_W  head destination
- rf_wr_data  out  16  head data
- retired_cnt  out  16  accepted-operation count
- fwd_q_addr  in  ADDR_W  forwarding query (FWD only)
- fwd_hit  out  1  pending write to fwd_q_addr (FWD only)
- fwd_data  out  16  youngest matching pending data (FWD only)

Behaviour:
- Reset (async assert, sync release): FIFO empty, rf_wr_en=0, zero_flag=0, carry_flag=0, retired_cnt=0, in_ready=1. Reset mid-operation drops all pending writes.
- Accept when in_valid && in_ready. in_ready = (count < DEPTH). It is computed from registered count only, with no combinational path from rf_wr_ready.
- On accept, effective = alu_cond_met.
  - If effective && in_flags_en: zero_flag <= alu_zero and carry_flag <= alu_carry, visible next cycle, so back-to-back dependent adc/sbc sees the updated C.
  - If effective && in_wr_en && !(ZERO_REG && in_rd==0): push {in_rd, alu_out[15:0]}. Bit 16 is never stored.
  - Otherwise the operation is squashed: no push, no flag change.
- retired_cnt increments on every accept, squashed or not, and wraps 0xFFFF→0x0000.
- Write port: rf_wr_en = (count != 0); addr and data come from the FIFO head. Pop when rf_wr_en && rf_wr_ready. Writes are issued strictly in accept order.
- Latency: accepted at cycle N, earliest rf_wr_en is cycle N+1.
- Simultaneous push and pop: count unchanged, order preserved. Push while count==DEPTH cannot occur because in_ready=0.
- The pointers wrap modulo DEPTH. An extra count bit distinguishes full from empty.
- rf_wr_addr and rf_wr_data hold stable while rf_wr_en && !rf_wr_ready.
- in_valid while in_ready=0: ignored. Flags and counter are not affected; upstream must hold the result.

Optional Feature:
- Macro: ALU_WB_FWD_EN.
- Defined: the fwd_q_addr, fwd_hit and fwd_data ports exist.
  - fwd_hit=1 when any valid FIFO entry has addr==fwd_q_addr.
  - fwd_data comes from the youngest such entry.
  - The lookup is combinational over FIFO contents only; it does not include the same-cycle input.
  - With ZERO_REG=1, a query of register 0 always gives hit=0.
- Not defined: the three ports are absent and no compare logic is built.

Test Plan:
- Reset, then accept alu_out=0x1_0000, alu_zero=1, alu_carry=1, flags_en=1, wr_en=1, rd=2, with rf_wr_ready=1. Required: next cycle zero_flag=1, carry_flag=1, rf_wr_en=1, addr=2, data=0x0000; retired_cnt=1.
- Hold rf_wr_ready=0 and accept writes to r1=0x1111, r3=0x3333, r5=0x5555. Required: in_ready=0 after 2 accepts and the third is held; release ready; writes emerge 0x1111, 0x3333, 0x5555 in order.
- alu_cond_met=0 with wr_en=1 and flags_en=1. Required: no rf_wr_en, flags unchanged, retired_cnt still increments.
- ZERO_REG=1, write rd=0 with data 0xBEEF. Required: no write and no FIFO occupancy. Also push and pop in the same cycle at count=1: count stays 1.
- Preload retired_cnt to 0xFFFF via 65535 accepts, accept one more. Required: 0x0000. Assert rst mid-stall: rf_wr_en=0 immediately, FIFO empty.
- ALU_WB_FWD_EN: pending r4=0x00AA then r4=0x00BB with ready=0. Required: query 4 gives hit=1, data=0x00BB; query 6 gives hit=0.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// -------------------
// Execute-to-writeback stage sitting directly behind the 16-bit ALU.
//  * Captures each ALU result together with its destination register.
//  * Owns the architectural zero/carry flags and feeds them back to the ALU.
//  * Buffers register-file writes in a small in-order FIFO so that the shared
//    register-file write port can apply backpressure.
//  * Counts every accepted (retired) operation, squashed or not.
//
// Optional feature (macro ALU_WB_FWD_EN):
//   When defined, a combinational forwarding lookup over the pending FIFO
//   entries is built and the fwd_q_addr / fwd_hit / fwd_data ports exist.
//   When undefined, those ports and the compare logic are absent.
//
// Parameters:
//   DEPTH    write-buffer entries (power of two, >= 2)
//   ADDR_W   register index width
//   ZERO_REG when 1, writes to register 0 are discarded
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  result handshake from the ALU
//   alu_out         17-bit ALU result (bit 16 carry-out, not stored)
//   alu_zero/carry  ALU flag outputs
//   alu_cond_met    operation condition; 0 squashes the operation
//   in_rd/in_wr_en  destination register and write enable
//   in_flags_en     operation updates the flags
//   zero_flag/carry_flag  architectural flags back to the ALU
//   rf_wr_*         register-file write port (FIFO head)
//   retired_cnt     count of accepted operations (wraps)
//   fwd_*           forwarding query (ALU_WB_FWD_EN only)

module alu_writeback_stage #(
  parameter int DEPTH    = 2,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [16:0]       alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_cond_met,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              in_flags_en,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              rf_wr_en,
  input  logic              rf_wr_ready,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [15:0]       rf_wr_data,
  output logic [15:0]       retired_cnt
`ifdef ALU_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_q_addr,
  output logic              fwd_hit,
  output logic [15:0]       fwd_data
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that a full FIFO is distinguishable from an empty one.
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [15:0]       retired_q, retired_d;

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [15:0]       mem_data_q [DEPTH];

  logic              accept_s;
  logic              zero_dest_s;
  logic              push_s;
  logic              pop_s;
  logic              flags_upd_s;

  // Carry-out of the ALU result is never stored; only the flag path uses carry.
  logic              unused_carry_bit_s;
  assign unused_carry_bit_s = alu_out[16];

  // in_ready depends only on registered occupancy, never on rf_wr_ready.
  assign in_ready    = (count_q < CNT_W'(DEPTH));
  assign accept_s    = in_valid & in_ready;
  assign zero_dest_s = (ZERO_REG != 0) && (in_rd == {ADDR_W{1'b0}});
  assign push_s      = accept_s & alu_cond_met & in_wr_en & ~zero_dest_s;
  assign flags_upd_s = accept_s & alu_cond_met & in_flags_en;
  assign pop_s       = rf_wr_en & rf_wr_ready;

  assign rf_wr_en    = (count_q != {CNT_W{1'b0}});
  assign rf_wr_addr  = mem_addr_q[rd_ptr_q];
  assign rf_wr_data  = mem_data_q[rd_ptr_q];
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;
  assign retired_cnt = retired_q;

  // Next-state computation for pointers, occupancy, flags and counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    retired_d = retired_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flags_upd_s) begin
      zero_d  = alu_zero;
      carry_d = alu_carry;
    end else begin
      zero_d  = zero_q;
      carry_d = carry_q;
    end

    // Squashed operations still retire and are counted.
    if (accept_s) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // State register for pointers, occupancy, flags and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      retired_q <= retired_d;
    end
  end

  // FIFO storage: written at the tail on push, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= {ADDR_W{1'b0}};
        mem_data_q[i] <= 16'd0;
      end
    end else if (push_s) begin
      mem_addr_q[wr_ptr_q] <= in_rd;
      mem_data_q[wr_ptr_q] <= alu_out[15:0];
    end else begin
      mem_addr_q[wr_ptr_q] <= mem_addr_q[wr_ptr_q];
      mem_data_q[wr_ptr_q] <= mem_data_q[wr_ptr_q];
    end
  end

`ifdef ALU_WB_FWD_EN
  logic              fwd_hit_s;
  logic [15:0]       fwd_data_s;
  logic              fwd_q_zero_s;

  // A register-0 query can never hit when register 0 is hard-wired.
  assign fwd_q_zero_s = (ZERO_REG != 0) && (fwd_q_addr == {ADDR_W{1'b0}});

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 16'd0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx_s;
      logic             match_s;
      idx_s      = rd_ptr_q + PTR_W'(i);
      match_s    = (CNT_W'(i) < count_q) && (mem_addr_q[idx_s] == fwd_q_addr)
                   && !fwd_q_zero_s;
      fwd_hit_s  = fwd_hit_s | match_s;
      fwd_data_s = match_s ? mem_data_q[idx_s] : fwd_data_s;
    end
  end

  assign fwd_hit  = fwd_hit_s;
  assign fwd_data = fwd_data_s;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage (DEPTH=2, ADDR_W=3, ZERO_REG=1).
// A reference model (queue of pending writes, flag and counter values) is
// updated at every falling edge from the stimulus; the same process compares
// every DUT output against it, plus directed checks from the test plan.

module tb_alu_writeback_stage;

  localparam int DEPTH    = 2;
  localparam int ADDR_W   = 3;
  localparam int ZERO_REG = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [16:0]       alu_out;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_cond_met;
  logic [ADDR_W-1:0] in_rd;
  logic              in_wr_en;
  logic              in_flags_en;
  logic              zero_flag;
  logic              carry_flag;
  logic              rf_wr_en;
  logic              rf_wr_ready;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [15:0]       rf_wr_data;
  logic [15:0]       retired_cnt;
`ifdef ALU_WB_FWD_EN
  logic [ADDR_W-1:0] fwd_q_addr;
  logic              fwd_hit;
  logic [15:0]       fwd_data;
`endif

  alu_writeback_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_cond_met (alu_cond_met),
    .in_rd        (in_rd),
    .in_wr_en     (in_wr_en),
    .in_flags_en  (in_flags_en),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_ready  (rf_wr_ready),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .retired_cnt  (retired_cnt)
`ifdef ALU_WB_FWD_EN
    ,
    .fwd_q_addr   (fwd_q_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit rand_ready = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic        m_zero;
  logic        m_carry;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // Reference model and monitor, evaluated at each falling edge.
  initial begin
    int   occ;
    bit   exp_ready;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_zero  = 1'b0;
        m_carry = 1'b0;
        m_cnt   = 16'd0;
      end else begin
        occ       = exp_q.size();
        exp_ready = (occ < DEPTH);
        chk("in_ready", in_ready, exp_ready);
        chk("zero_flag", zero_flag, m_zero);
        chk("carry_flag", carry_flag, m_carry);
        chk("retired_cnt", retired_cnt, m_cnt);
        chk("rf_wr_en", rf_wr_en, occ != 0);
        if (occ != 0) begin
          chk("rf_wr_addr", rf_wr_addr, exp_q[0].addr);
          chk("rf_wr_data", rf_wr_data, exp_q[0].data);
        end
`ifdef ALU_WB_FWD_EN
        begin
          bit          e_hit;
          logic [15:0] e_data;
          e_hit  = 1'b0;
          e_data = 16'd0;
          for (int i = occ - 1; i >= 0; i--) begin
            if (!e_hit && exp_q[i].addr == fwd_q_addr) begin
              e_hit  = 1'b1;
              e_data = exp_q[i].data;
            end
          end
          chk("fwd_hit", fwd_hit, e_hit);
          if (e_hit) chk("fwd_data", fwd_data, e_data);
        end
`endif
        // The register file takes the head write at the coming edge.
        if (occ != 0 && rf_wr_ready) void'(exp_q.pop_front());
        // An offered result is taken when the buffer has room.
        if (in_valid && exp_ready) begin
          m_cnt = m_cnt + 16'd1;
          if (alu_cond_met) begin
            if (in_flags_en) begin
              m_zero  = alu_zero;
              m_carry = alu_carry;
            end
            if (in_wr_en && !(ZERO_REG != 0 && in_rd == 0))
              exp_q.push_back('{addr: in_rd, data: alu_out[15:0]});
          end
        end
      end
    end
  end

  // Offer one result and hold it until it is accepted (bounded).
  task automatic send(input logic [16:0] res, input logic z, input logic c,
                      input logic cond, input logic [ADDR_W-1:0] rd,
                      input logic we, input logic fe);
    bit acc;
    int n;
    alu_out = res; alu_zero = z; alu_carry = c; alu_cond_met = cond;
    in_rd = rd; in_wr_en = we; in_flags_en = fe; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (rand_ready) begin
        rf_wr_ready = 1'($urandom_range(0, 1));
`ifdef ALU_WB_FWD_EN
        fwd_q_addr = ADDR_W'($urandom_range(0, 7));
`endif
      end
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    fails++;
    summary();
    $finish;
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; alu_out = 17'd0; alu_zero = 1'b0; alu_carry = 1'b0;
    alu_cond_met = 1'b0; in_rd = 3'd0; in_wr_en = 1'b0; in_flags_en = 1'b0;
    rf_wr_ready = 1'b1;
`ifdef ALU_WB_FWD_EN
    fwd_q_addr = 3'd0;
`endif
    #1;
    chk("reset_rf_wr_en", rf_wr_en, 32'd0);
    chk("reset_in_ready", in_ready, 32'd1);
    chk("reset_retired", retired_cnt, 32'd0);
    chk("reset_flags", {zero_flag, carry_flag}, 32'd0);
    cycles(2);
    rst = 1'b0;

    // First accept: flags and write visible next cycle, carry-out dropped.
    send(17'h1_0000, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
    chk("t1_zero", zero_flag, 32'd1);
    chk("t1_carry", carry_flag, 32'd1);
    chk("t1_wr_en", rf_wr_en, 32'd1);
    chk("t1_addr", rf_wr_addr, 32'd2);
    chk("t1_data", rf_wr_data, 32'h0000);
    chk("t1_cnt", retired_cnt, 32'd1);
    cycles(1);

    // Backpressure: two accepts fill the buffer, third is held.
    rf_wr_ready = 1'b0;
    send(17'h0_1111, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    send(17'h0_3333, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    chk("t2_full_ready", in_ready, 32'd0);
    fork
      send(17'h0_5555, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
      begin
        cycles(4);
        #1;
        rf_wr_ready = 1'b1;
      end
    join
    cycles(4);
    chk("t2_cnt", retired_cnt, 32'd4);

    // Squashed op: counted, no write, flags unchanged.
    send(17'h0_7777, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1);
    chk("t3_wr_en", rf_wr_en, 32'd0);
    chk("t3_flags", {zero_flag, carry_flag}, 32'd3);
    chk("t3_cnt", retired_cnt, 32'd5);

    // Write to r0 is discarded.
    send(17'h0_BEEF, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("t4_r0_wr_en", rf_wr_en, 32'd0);
    chk("t4_r0_ready", in_ready, 32'd1);
    // Push and pop in the same cycle at occupancy one.
    send(17'h0_0A11, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    send(17'h0_0B22, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    chk("t4_pp_wr_en", rf_wr_en, 32'd1);
    chk("t4_pp_addr", rf_wr_addr, 32'd2);
    chk("t4_pp_data", rf_wr_data, 32'h0B22);
    chk("t4_pp_ready", in_ready, 32'd1);
    cycles(3);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      send(17'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'($urandom));
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    rand_ready = 1'b0;
    rf_wr_ready = 1'b1;
    cycles(4);

    // Counter wrap after 65535 + 1 squashed accepts.
    do_reset();
    alu_cond_met = 1'b0; in_wr_en = 1'b0; in_flags_en = 1'b0; in_valid = 1'b1;
    cycles(65535);
    in_valid = 1'b0;
    chk("t5_cnt_max", retired_cnt, 32'hFFFF);
    send(17'h0_0000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    chk("t5_cnt_wrap", retired_cnt, 32'h0000);

    // Reset in the middle of a stall drops pending writes at once.
    rf_wr_ready = 1'b0;
    send(17'h0_1234, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
    send(17'h0_5678, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
    chk("t5_stall_wr_en", rf_wr_en, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_wr_en", rf_wr_en, 32'd0);
    chk("t5_rst_ready", in_ready, 32'd1);
    chk("t5_rst_flags", {zero_flag, carry_flag}, 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    chk("t5_post_wr_en", rf_wr_en, 32'd0);

`ifdef ALU_WB_FWD_EN
    // Forwarding: youngest pending match wins, unrelated register misses.
    send(17'h0_00AA, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    send(17'h0_00BB, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    fwd_q_addr = 3'd4;
    #1;
    chk("fwd_hit_r4", fwd_hit, 32'd1);
    chk("fwd_data_r4", fwd_data, 32'h00BB);
    fwd_q_addr = 3'd6;
    #1;
    chk("fwd_hit_r6", fwd_hit, 32'd0);
    fwd_q_addr = 3'd0;
    #1;
    chk("fwd_hit_r0", fwd_hit, 32'd0);
    rf_wr_ready = 1'b1;
    cycles(4);
`endif
    rf_wr_ready = 1'b1;
    cycles(2);

    summary();
    $finish;
  end

endmodule
